// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - oversampled mode-0 SPI slave with a host-accessible register file
module spi_slave_regs #(
   parameter int D = 8,
   parameter int A = 4
) (
   input  logic         CLOCK,
   input  logic         RESET_N,
   input  logic         SS,
   input  logic         SCLK,
   input  logic         MOSI,
   output logic         MISO,
   output logic         MISO_OE,
   output logic         WR_STB,
   output logic [A-1:0] WR_ADDR,
   output logic [D-1:0] WR_DATA,
   output logic         FRAME_ERR,
   input  logic         HOST_WR,
   input  logic [A-1:0] HOST_ADDR,
   input  logic [D-1:0] HOST_DI,
   output logic [D-1:0] HOST_DO
);

   localparam int MAXW  = (A > D) ? A : D;
   localparam int CW    = $clog2(MAXW + 1);
   localparam int DEPTH = 1 << A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_DONE
   } state_t;

   state_t         state, state_nxt;
   logic [2:0]     ss_s, sclk_s;
   logic [1:0]     mosi_s;
   logic [CW-1:0]  bit_cnt;
   logic           rw_q;
   logic [A-1:0]   addr_q;
   logic [D-1:0]   data_q;
   logic [D-1:0]   tx_q;
   logic           miso_q;
   logic           wr_stb_q;
   logic [A-1:0]   wr_addr_q;
   logic [D-1:0]   wr_data_q;
   logic           err_q;
   logic [D-1:0]   host_do_q;
   logic [D-1:0]   regs [DEPTH];

   logic           ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit;
   logic           last_addr, last_data;
   logic [A-1:0]   addr_nxt;
   logic [D-1:0]   data_nxt;
   logic           cnt_clr, cnt_inc, ld_rw, sh_addr, ld_tx, sh_tx, sh_data;
   logic           commit, abort;
   logic           host_we;

   // Edges come from the 2nd/3rd synchroniser stages so every pin sees the same latency.
   assign ss_fall   = ~ss_s[1] &  ss_s[2];
   assign ss_rise   =  ss_s[1] & ~ss_s[2];
   assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
   assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
   assign mosi_bit  = mosi_s[1];

   assign last_addr = (bit_cnt == CW'(A - 1));
   assign last_data = (bit_cnt == CW'(D - 1));
   assign addr_nxt  = (addr_q << 1) | A'(mosi_bit);
   assign data_nxt  = (data_q << 1) | D'(mosi_bit);

   // A host write colliding with an SPI commit to the same address is dropped.
   assign host_we   = HOST_WR && !(commit && (HOST_ADDR == addr_q));

   assign MISO      = miso_q;
   assign MISO_OE   = (state != ST_IDLE);
   assign WR_STB    = wr_stb_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;
   assign FRAME_ERR = err_q;
   assign HOST_DO   = host_do_q;

   // Two-flop synchronisers plus one extra stage for edge detection.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ss_s   <= '0;
         sclk_s <= '0;
         mosi_s <= '0;
      end else begin
         ss_s   <= {ss_s[1:0], SS};
         sclk_s <= {sclk_s[1:0], SCLK};
         mosi_s <= {mosi_s[0], MOSI};
      end
   end

   // FSM state register.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode and per-cycle datapath strobes; SS rise beats any SCLK edge.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      ld_rw     = 1'b0;
      sh_addr   = 1'b0;
      ld_tx     = 1'b0;
      sh_tx     = 1'b0;
      sh_data   = 1'b0;
      commit    = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_nxt = ST_CMD;
               cnt_clr   = 1'b1;
            end
         end
         ST_CMD: begin
            if (ss_rise) begin
               abort = 1'b1;
            end else if (sclk_rise) begin
               ld_rw     = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ss_rise) begin
               abort = 1'b1;
            end else if (sclk_rise) begin
               sh_addr = 1'b1;
               if (last_addr) begin
                  ld_tx     = rw_q;
                  cnt_clr   = 1'b1;
                  state_nxt = ST_DATA;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (ss_rise) begin
               abort = 1'b1;
            end else if (sclk_rise) begin
               sh_data = ~rw_q;
               if (last_data) begin
                  commit    = ~rw_q;
                  cnt_clr   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (sclk_fall && rw_q) begin
               sh_tx = 1'b1;
            end
         end
         ST_DONE: begin
            if (ss_rise) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
         cnt_clr   = 1'b1;
      end
   end

   // Frame datapath: bit counter, shifters, MISO driver and write/error pulses.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         bit_cnt   <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         tx_q      <= '0;
         miso_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + CW'(1);
         if (ld_rw)   rw_q   <= mosi_bit;
         if (sh_addr) addr_q <= addr_nxt;
         if (sh_data) data_q <= data_nxt;
         // Read data is snapshotted here so later host writes cannot disturb the frame.
         if (ld_tx) begin
            tx_q <= regs[addr_nxt];
         end else if (sh_tx) begin
            tx_q <= tx_q << 1;
         end
         if (sh_tx)                    miso_q <= tx_q[D-1];
         else if (state_nxt != ST_DATA) miso_q <= 1'b0;
         wr_stb_q <= commit;
         if (commit) begin
            wr_addr_q <= addr_q;
            wr_data_q <= data_nxt;
         end
         err_q <= abort;
      end
   end

   // Register file with SPI-priority write and registered host read port.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         host_do_q <= '0;
      end else begin
         if (host_we) regs[HOST_ADDR] <= HOST_DI;
         if (commit)  regs[addr_q]    <= data_nxt;
         host_do_q <= regs[HOST_ADDR];
      end
   end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- Synchronous SPI slave (responder) with an internal 2^A x D register file. It is the far end of the SPI master's WR/RD transactions.
- It oversamples SS/SCLK/MOSI in the system CLOCK domain, decodes command/address/data frames, and updates or returns register contents.
- A local host port gives on-chip logic read/write access to the same registers and reports every SPI write.

Parameters:
- D, 8, data width in bits
- A, 4, address width in bits; register file depth 2^A

Ports:
- CLOCK  input  1  system clock, rising-edge
- RESET_N  input  1  asynchronous active-low reset
- SS  input  1  SPI slave select, active-low
- SCLK  input  1  SPI clock, mode 0 (idle low)
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master
- MISO_OE  output  1  high while selected; MISO drive enable
- WR_STB  output  1  one-cycle pulse when an SPI write commits
- WR_ADDR  output  A  address of the committed SPI write
- WR_DATA  output  D  data of the committed SPI write
- FRAME_ERR  output  1  one-cycle pulse when a frame aborts early
- HOST_WR  input  1  local register write enable
- HOST_ADDR  input  A  local read/write address
- HOST_DI  input  D  local write data
- HOST_DO  output  D  local read data, registered

Behaviour:
- Reset (RESET_N low, async):
  - all registers, outputs and state go to 0; FSM goes to IDLE.
  - MISO=0, MISO_OE=0, WR_STB=0, FRAME_ERR=0, HOST_DO=0.
- Input synchronisation and sampling:
  - SS, SCLK and MOSI each pass through 2-flop synchronisers; edges are detected from the 2nd/3rd stages.
  - SCLK rise/fall is detected 3 CLOCK cycles after the pin edge.
  - Requirement: SCLK high and low phases are each >= 4 CLOCK periods.
- Frame format (mode 0, MSB first, 1+A+D bits):
  - bit 1 is RW (1=read, 0=write), then A address bits, then D data bits.
  - MOSI is sampled on SCLK rise; MISO updates on SCLK fall.
- FSM states: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE -> CMD on synced SS fall; bit counter cleared; MISO_OE=1.
  - CMD: first SCLK rise latches RW -> ADDR.
  - ADDR: A rises shift in the address. On the A-th rise, the addressed register is latched into the tx shifter if RW=1 -> DATA.
  - DATA, read: MISO presents tx MSB at the first SCLK fall after entering DATA, then shifts one bit per fall. MOSI is ignored.
  - DATA, write: D rises shift in data. On the D-th rise the register is written and WR_STB pulses the next cycle, with WR_ADDR/WR_DATA valid and held until the next commit. -> DONE.
  - DONE: further SCLK edges are ignored and MISO holds 0. -> IDLE on synced SS rise.
  - Any state other than IDLE/DONE: synced SS rise -> IDLE plus a one-cycle FRAME_ERR pulse. No register write occurs and all counters clear.
  - MISO=0 and MISO_OE=0 whenever in IDLE.
- Host port:
  - HOST_DO = reg[HOST_ADDR], registered, 1-cycle latency.
  - HOST_WR writes HOST_DI on the clock edge.
  - If HOST_WR and an SPI commit hit the same address in the same cycle, the SPI write wins and HOST_WR is dropped.
  - When the addresses differ, both writes occur.
- Read data snapshot:
  - Read data is captured at the end of the ADDR phase.
  - A host write to that address during the DATA phase does not change bits already latched for the frame.
- Reset mid-frame: immediate IDLE with no partial write. The next SS fall after release starts a clean frame.

Test Plan:
- SPI write 205 to addr 7 (frame 0_0111_11001101) -> WR_STB single pulse, WR_ADDR=7, WR_DATA=205; then HOST_ADDR=7 gives HOST_DO=205 after 1 cycle.
- Host writes 0xA5 to addr 3, then SPI read addr 3 -> MISO bits on the 8 data rises = 1,0,1,0,0,1,0,1; MISO_OE=1 only while SS low; no WR_STB.
- SPI write to addr 2 with SS raised after 4 data bits -> FRAME_ERR pulse, no WR_STB, reg[2] unchanged; the following full frame completes normally.
- Same-cycle HOST_WR (0x11) and SPI commit (0x22) to addr 5 -> reg[5]=0x22. Repeat with HOST_WR to addr 6 -> reg[5]=0x22 and reg[6]=0x11.
- RESET_N pulsed low mid-ADDR phase -> all outputs 0 immediately, registers cleared, FSM in IDLE; the next write frame completes correctly.
- Extra SCLK pulses after a complete read frame with SS still low -> MISO stays 0, no FRAME_ERR; SS rise returns to IDLE silently.
